gf_mult_scheduler: RTL and testbench

//  Shares one GF(2^163) field multiplier (Karatsuba product + reducer, combinational)

---
 rtl/gf_mult_scheduler.sv | 155 +++++++++++++++
 tb/tb_gf_mult_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult_scheduler.sv
// Round-robin scheduler sharing one combinational GF(2^FIELD_W) multiplier between NREQ requesters.
// State | meaning:  IDLE - arbitrating | BUSY - waiting MUL_LAT cycles on mul_c | DONE - holding result for consumer
module gf_mult_scheduler #(
    parameter int                 FIELD_W = 163,
    parameter int                 NREQ    = 2,
    parameter int                 MUL_LAT = 1,
    parameter logic [FIELD_W-1:0] POLY    = 163'hC9,
    localparam int                ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*FIELD_W-1:0] i_req_a,
    input  logic [NREQ*FIELD_W-1:0] i_req_b,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [FIELD_W-1:0]      o_rsp_c,
    output logic                    o_busy,
    output logic [FIELD_W-1:0]      o_mul_a,
    output logic [FIELD_W-1:0]      o_mul_b,
    output logic [FIELD_W-1:0]      o_mul_p,
    input  logic [FIELD_W-1:0]      i_mul_c
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_rsp_id;
    logic                 r_rsp_valid;
    logic [FIELD_W-1:0]   r_rsp_c;
    logic [FIELD_W-1:0]   r_mul_a;
    logic [FIELD_W-1:0]   r_mul_b;

    logic                 w_grant_vld;
    logic [ID_W-1:0]      w_grant_id;
    logic [FIELD_W-1:0]   w_sel_a;
    logic [FIELD_W-1:0]   w_sel_b;
    logic [NREQ-1:0]      w_req_ready;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_release;

    // Search starts at the round-robin pointer and wraps; first valid requester wins.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_grant_vld && i_req_valid[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_W'(v_idx);
                w_sel_a     = i_req_a[v_idx*FIELD_W +: FIELD_W];
                w_sel_b     = i_req_b[v_idx*FIELD_W +: FIELD_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_req_ready[w_grant_id] = 1'b1;
                    w_accept                = 1'b1;
                    w_state_nxt             = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands only move on accept so mul_c may be timed as a MUL_LAT multicycle path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_c     <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a  <= w_sel_a;
                r_mul_b  <= w_sel_b;
                r_rsp_id <= w_grant_id;
                r_cnt    <= CNT_W'(MUL_LAT - 1);
            end
            if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_c     <= i_mul_c;
                r_rsp_valid <= 1'b1;
            end
            if (w_release) begin
                r_rsp_valid <= 1'b0;
                if (int'(r_rsp_id) == NREQ - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_rsp_id + 1'b1;
                end
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_c     = r_rsp_c;
    assign o_busy      = (r_state != S_IDLE);
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_mul_p     = POLY;

endmodule

// File: tb/tb_gf_mult_scheduler.sv
// Directed bench for gf_mult_scheduler: one instance with MUL_LAT=1, one with MUL_LAT=3.
module tb_gf_mult_scheduler;
    localparam int W = 163;
    localparam logic [W-1:0] POLY = 163'hC9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]     req_valid1, req_ready1, req_valid3, req_ready3;
    logic [2*W-1:0] req_a1, req_b1, req_a3, req_b3;
    logic           rsp_valid1, rsp_ready1, busy1, en1;
    logic           rsp_valid3, rsp_ready3, busy3, en3;
    logic [0:0]     rsp_id1, rsp_id3;
    logic [W-1:0]   rsp_c1, mul_a1, mul_b1, mul_p1, mul_c1;
    logic [W-1:0]   rsp_c3, mul_a3, mul_b3, mul_p3, mul_c3;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference GF(2^163) multiply, polynomial basis, MSB-first shift-and-add.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = {r[W-2:0], 1'b0} ^ (r[W-1] ? p : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    assign mul_c1 = en1 ? gf_mul(mul_a1, mul_b1, mul_p1) : {W{1'bx}};
    assign mul_c3 = en3 ? gf_mul(mul_a3, mul_b3, mul_p3) : {W{1'bx}};

    gf_mult_scheduler #(.FIELD_W(W), .NREQ(2), .MUL_LAT(1), .POLY(POLY)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid1), .o_req_ready(req_ready1),
        .i_req_a(req_a1), .i_req_b(req_b1),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1),
        .o_rsp_id(rsp_id1), .o_rsp_c(rsp_c1), .o_busy(busy1),
        .o_mul_a(mul_a1), .o_mul_b(mul_b1), .o_mul_p(mul_p1), .i_mul_c(mul_c1)
    );

    gf_mult_scheduler #(.FIELD_W(W), .NREQ(2), .MUL_LAT(3), .POLY(POLY)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid3), .o_req_ready(req_ready3),
        .i_req_a(req_a3), .i_req_b(req_b3),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
        .o_rsp_id(rsp_id3), .o_rsp_c(rsp_c3), .o_busy(busy3),
        .o_mul_a(mul_a3), .o_mul_b(mul_b3), .o_mul_p(mul_p3), .i_mul_c(mul_c3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b0; en1 = 1'b0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0; en3 = 1'b0;
        #12;
        tests_run++;
        if ({req_ready1, rsp_valid1, rsp_id1, busy1} !== 5'b0 || rsp_c1 !== '0
            || mul_a1 !== '0 || mul_b1 !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut1: rdy=%b vld=%b id=%b busy=%b c=%h a=%h b=%h, want all 0",
                     req_ready1, rsp_valid1, rsp_id1, busy1, rsp_c1, mul_a1, mul_b1);
        end
        tests_run++;
        if ({req_ready3, rsp_valid3, rsp_id3, busy3} !== 5'b0 || rsp_c3 !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut3: rdy=%b vld=%b id=%b busy=%b c=%h, want all 0",
                     req_ready3, rsp_valid3, rsp_id3, busy3, rsp_c3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({busy1, rsp_valid1, busy3, rsp_valid3} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy1=%b vld1=%b busy3=%b vld3=%b, want 0",
                     busy1, rsp_valid1, busy3, rsp_valid3);
        end
    endtask

    task automatic test_single_op();
        req_a1[0 +: W] = W'(2); req_b1[0 +: W] = W'(2); req_valid1 = 2'b01;
        #1;
        tests_run++;
        if ({busy1, req_ready1} !== 3'b001) begin
            tests_failed++;
            $display("FAIL single_grant: busy/ready=%b, want 001", {busy1, req_ready1});
        end
        tick();
        req_valid1 = 2'b00;
        tests_run++;
        if ({busy1, rsp_valid1, req_ready1} !== 4'b1000 || mul_a1 !== W'(2) || mul_b1 !== W'(2)) begin
            tests_failed++;
            $display("FAIL single_launch: busy/vld/rdy=%b a=%h b=%h, want 1000 a=2 b=2",
                     {busy1, rsp_valid1, req_ready1}, mul_a1, mul_b1);
        end
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        tests_run++;
        if ({busy1, rsp_valid1, rsp_id1} !== 3'b110 || rsp_c1 !== W'(4)) begin
            tests_failed++;
            $display("FAIL single_result: busy/vld/id=%b c=%h, want 110 c=4",
                     {busy1, rsp_valid1, rsp_id1}, rsp_c1);
        end
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        tests_run++;
        if ({busy1, rsp_valid1} !== 2'b00 || rsp_c1 !== W'(4)) begin
            tests_failed++;
            $display("FAIL single_handshake: busy/vld=%b c=%h, want 00 c=4 held",
                     {busy1, rsp_valid1}, rsp_c1);
        end
    endtask

    task automatic test_reduction();
        logic [W-1:0] a;
        a = '0;
        a[W-1] = 1'b1;
        req_a1[0 +: W] = a; req_b1[0 +: W] = W'(2); req_valid1 = 2'b01;
        tick();
        req_valid1 = 2'b00;
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        tests_run++;
        if (rsp_valid1 !== 1'b1 || rsp_c1 !== 163'hC9) begin
            tests_failed++;
            $display("FAIL reduction: vld=%b c=%h, want 1 c=c9", rsp_valid1, rsp_c1);
        end
        tests_run++;
        if (mul_p1 !== 163'hC9 || mul_p3 !== 163'hC9) begin
            tests_failed++;
            $display("FAIL mul_p: p1=%h p3=%h, want c9", mul_p1, mul_p3);
        end
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
    endtask

    task automatic test_contention();
        logic [W-1:0] opa [4];
        logic [W-1:0] opb [4];
        logic [W-1:0] expc [4];
        logic [1:0]   exp_rdy;
        int g;
        opa  = '{W'(3), W'(6), W'(7), W'(16)};
        opb  = '{W'(5), W'(3), W'(7), W'(16)};
        expc = '{W'(15), W'(10), W'(21), W'(256)};
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        req_a1[0 +: W] = opa[0]; req_b1[0 +: W] = opb[0];
        req_a1[W +: W] = opa[1]; req_b1[W +: W] = opb[1];
        req_valid1 = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            exp_rdy = (g == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (req_ready1 !== exp_rdy) begin
                tests_failed++;
                $display("FAIL contention_grant%0d: ready=%b, want %b", i, req_ready1, exp_rdy);
            end
            tick();
            if (i + 2 < 4) begin
                req_a1[g*W +: W] = opa[i+2];
                req_b1[g*W +: W] = opb[i+2];
            end else begin
                req_valid1[g] = 1'b0;
            end
            tests_run++;
            if ({busy1, req_ready1} !== 3'b100) begin
                tests_failed++;
                $display("FAIL contention_busy%0d: busy/ready=%b, want 100", i, {busy1, req_ready1});
            end
            en1 = 1'b1;
            tick();
            en1 = 1'b0;
            tests_run++;
            if (rsp_valid1 !== 1'b1 || rsp_id1 !== 1'(g) || rsp_c1 !== expc[i]) begin
                tests_failed++;
                $display("FAIL contention_rsp%0d: vld=%b id=%b c=%h, want 1 id=%0d c=%h",
                         i, rsp_valid1, rsp_id1, rsp_c1, g, expc[i]);
            end
            rsp_ready1 = 1'b1;
            tick();
            rsp_ready1 = 1'b0;
        end
        req_valid1 = 2'b00;
    endtask

    task automatic test_backpressure();
        req_a1[W +: W] = W'(9); req_b1[W +: W] = W'(3); req_valid1 = 2'b10;
        #1;
        tests_run++;
        if (req_ready1 !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_grant: ready=%b, want 10", req_ready1);
        end
        tick();
        req_valid1 = 2'b01;
        req_a1[0 +: W] = W'(1); req_b1[0 +: W] = W'(1);
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({rsp_valid1, rsp_id1, req_ready1, busy1} !== 5'b11001 || rsp_c1 !== W'(27)
                || mul_a1 !== W'(9) || mul_b1 !== W'(3)) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: vld/id/rdy/busy=%b c=%h a=%h b=%h, want 11001 c=1b a=9 b=3",
                         i, {rsp_valid1, rsp_id1, req_ready1, busy1}, rsp_c1, mul_a1, mul_b1);
            end
            tick();
        end
        req_valid1 = 2'b11;
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        tests_run++;
        if ({rsp_valid1, req_ready1} !== 3'b001) begin
            tests_failed++;
            $display("FAIL bp_release: vld/ready=%b, want 001", {rsp_valid1, req_ready1});
        end
        req_valid1 = 2'b00;
    endtask

    task automatic test_latency3();
        req_a3[0 +: W] = W'(5); req_b3[0 +: W] = W'(5); req_valid3 = 2'b01;
        #1;
        tests_run++;
        if (req_ready3 !== 2'b01) begin
            tests_failed++;
            $display("FAIL lat3_grant: ready=%b, want 01", req_ready3);
        end
        tick();
        req_valid3 = 2'b00;
        for (int e = 0; e < 3; e++) begin
            tests_run++;
            if ({busy3, rsp_valid3} !== 2'b10) begin
                tests_failed++;
                $display("FAIL lat3_wait%0d: busy/vld=%b, want 10", e, {busy3, rsp_valid3});
            end
            if (e == 2) en3 = 1'b1;
            tick();
        end
        en3 = 1'b0;
        tests_run++;
        if ({rsp_valid3, rsp_id3} !== 2'b10 || rsp_c3 !== W'(17)) begin
            tests_failed++;
            $display("FAIL lat3_result: vld/id=%b c=%h, want 10 c=11", {rsp_valid3, rsp_id3}, rsp_c3);
        end
        tick();
        req_a3[0 +: W] = W'(6); req_b3[0 +: W] = W'(6);
        req_a3[W +: W] = W'(3); req_b3[W +: W] = W'(3);
        req_valid3 = 2'b11;
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        tests_run++;
        if (mul_a3 !== W'(5) || mul_b3 !== W'(5) || req_ready3 !== 2'b10) begin
            tests_failed++;
            $display("FAIL lat3_idle: a=%h b=%h ready=%b, want a=5 b=5 ready=10", mul_a3, mul_b3, req_ready3);
        end
        tick();
        req_valid3 = 2'b00;
        tests_run++;
        if (mul_a3 !== W'(3) || mul_b3 !== W'(3) || rsp_id3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat3_launch2: a=%h b=%h id=%b, want a=3 b=3 id=1", mul_a3, mul_b3, rsp_id3);
        end
        tick();
        tick();
        en3 = 1'b1;
        tick();
        en3 = 1'b0;
        tests_run++;
        if (rsp_valid3 !== 1'b1 || rsp_c3 !== W'(5)) begin
            tests_failed++;
            $display("FAIL lat3_result2: vld=%b c=%h, want 1 c=5", rsp_valid3, rsp_c3);
        end
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
    endtask

    task automatic test_async_reset();
        req_a1[0 +: W] = W'(1); req_b1[0 +: W] = W'(1); req_valid1 = 2'b01;
        tick();
        req_valid1 = 2'b00;
        en1 = 1'b1;
        tick();
        en1 = 1'b0;
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        req_a1[W +: W] = W'(3); req_b1[W +: W] = W'(2); req_valid1 = 2'b10;
        tick();
        req_valid1 = 2'b00;
        tests_run++;
        if ({busy1, rsp_id1} !== 2'b11 || rsp_c1 !== W'(1)) begin
            tests_failed++;
            $display("FAIL areset_pre: busy/id=%b c=%h, want 11 c=1", {busy1, rsp_id1}, rsp_c1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready1, rsp_valid1, rsp_id1, busy1} !== 5'b0 || rsp_c1 !== '0
            || mul_a1 !== '0 || mul_b1 !== '0) begin
            tests_failed++;
            $display("FAIL areset_mid: rdy=%b vld=%b id=%b busy=%b c=%h a=%h b=%h, want all 0",
                     req_ready1, rsp_valid1, rsp_id1, busy1, rsp_c1, mul_a1, mul_b1);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({busy1, rsp_valid1} !== 2'b00) begin
                tests_failed++;
                $display("FAIL areset_quiet%0d: busy/vld=%b, want 00", i, {busy1, rsp_valid1});
            end
        end
        req_valid1 = 2'b11;
        #1;
        tests_run++;
        if (req_ready1 !== 2'b01) begin
            tests_failed++;
            $display("FAIL areset_rrptr: ready=%b, want 01", req_ready1);
        end
        req_valid1 = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_reduction();
        test_contention();
        test_backpressure();
        test_latency3();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
